// File: rtl/pipelined_alu.sv
// Integer ALU feeding a STAGES-deep result pipeline with valid/ready handshakes.
// Issue-to-result latency is STAGES cycles; empty stages collapse under backpressure.
module pipelined_alu #(
   parameter int XLEN   = 32,
   parameter int STAGES = 2,
   parameter int ROB_W  = 6,
   parameter int PREG_W = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [XLEN-1:0]   operand_a_i,
   input  logic [XLEN-1:0]   operand_b_i,
   input  logic [3:0]        alu_op_i,
   input  logic [ROB_W-1:0]  rob_id_i,
   input  logic [PREG_W-1:0] phys_dest_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [XLEN-1:0]   result_o,
   output logic [ROB_W-1:0]  rob_id_o,
   output logic [PREG_W-1:0] phys_dest_o,
   output logic              exception_o,
   output logic              busy_o
);

   localparam int SH_W = $clog2(XLEN);

   typedef struct packed {
      logic              exc;
      logic [PREG_W-1:0] dest;
      logic [ROB_W-1:0]  rob;
      logic [XLEN-1:0]   res;
   } beat_t;

   beat_t             alu_dat;
   beat_t             stg_dat [STAGES];
   logic [STAGES-1:0] stg_vld;
   logic [STAGES-1:0] acc;
   logic              issue;
   logic              lt_s;
   logic              lt_u;
   logic [SH_W-1:0]   shamt;

   always_comb begin
      lt_s          = $signed(operand_a_i) < $signed(operand_b_i);
      lt_u          = operand_a_i < operand_b_i;
      shamt         = operand_b_i[SH_W-1:0];
      alu_dat.rob   = rob_id_i;
      alu_dat.dest  = phys_dest_i;
      alu_dat.exc   = 1'b0;
      alu_dat.res   = '0;
      case (alu_op_i)
         4'h0:    alu_dat.res = operand_a_i + operand_b_i;
         4'h1:    alu_dat.res = operand_a_i - operand_b_i;
         4'h2:    alu_dat.res = operand_a_i & operand_b_i;
         4'h3:    alu_dat.res = operand_a_i | operand_b_i;
         4'h4:    alu_dat.res = operand_a_i ^ operand_b_i;
         4'h5:    alu_dat.res = operand_a_i << shamt;
         4'h6:    alu_dat.res = operand_a_i >> shamt;
         4'h7:    alu_dat.res = $signed(operand_a_i) >>> shamt;
         4'h8:    alu_dat.res = XLEN'(lt_s);
         4'h9:    alu_dat.res = XLEN'(lt_u);
         4'hA:    alu_dat.res = lt_s ? operand_a_i : operand_b_i;
         4'hB:    alu_dat.res = lt_s ? operand_b_i : operand_a_i;
         4'hC:    alu_dat.res = lt_u ? operand_a_i : operand_b_i;
         4'hD:    alu_dat.res = lt_u ? operand_b_i : operand_a_i;
         default: alu_dat.exc = 1'b1;
      endcase
   end

   // A stage can take new data if writeback accepts or any stage at or after it is a bubble.
   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         acc[k] = ready_i;
         for (int j = k; j < STAGES; j++) begin
            if (!stg_vld[j]) acc[k] = 1'b1;
         end
      end
   end

   assign ready_o = acc[0];
   assign issue   = valid_i && ready_o && !flush_i;

   always_ff @(posedge clk) begin
      if (rst) begin
         stg_vld <= '0;
         for (int k = 0; k < STAGES; k++) stg_dat[k] <= '0;
      end else begin
         if (acc[0]) begin
            stg_vld[0] <= issue;
            stg_dat[0] <= alu_dat;
         end
         for (int k = 1; k < STAGES; k++) begin
            if (acc[k]) begin
               stg_vld[k] <= stg_vld[k-1];
               stg_dat[k] <= stg_dat[k-1];
            end
         end
         if (flush_i) stg_vld <= '0;
      end
   end

   assign valid_o     = stg_vld[STAGES-1];
   assign result_o    = stg_dat[STAGES-1].res;
   assign rob_id_o    = stg_dat[STAGES-1].rob;
   assign phys_dest_o = stg_dat[STAGES-1].dest;
   assign exception_o = stg_dat[STAGES-1].exc;
   assign busy_o      = |stg_vld;

endmodule

// File: tb/tb_pipelined_alu.sv
// Three ALU instances (32b/2 stages, 64b/1 stage, 64b/4 stages) checked against a queue scoreboard.
module tb_pipelined_alu;
   localparam int N = 3;

   typedef struct {
      logic [3:0]  op;
      logic [63:0] a;
      logic [63:0] b;
      logic [5:0]  rob;
      logic [6:0]  dst;
      logic [63:0] e32;
      logic [63:0] e64;
      logic        exc;
   } vec_t;

   typedef struct {
      logic [63:0] res;
      logic [5:0]  rob;
      logic [6:0]  dst;
      logic        exc;
      int          t;
   } exp_t;

   int st [N]  = '{2, 1, 4};
   bit w64 [N] = '{1'b0, 1'b1, 1'b1};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, flush, ready;
   logic        va [N];
   logic        rdy [N];
   logic        vo [N];
   logic        exc_o [N];
   logic        busy [N];
   logic [3:0]  opc [N];
   logic [63:0] opa [N];
   logic [63:0] opb [N];
   logic [63:0] res [N];
   logic [5:0]  rob_in [N];
   logic [5:0]  rob_o [N];
   logic [6:0]  dst_in [N];
   logic [6:0]  dst_o [N];
   logic [31:0] res32;

   assign res[0] = {32'h0, res32};

   pipelined_alu #(.XLEN(32), .STAGES(2)) d2 (
      .clk(clk), .rst(rst), .flush_i(flush), .valid_i(va[0]), .ready_o(rdy[0]),
      .operand_a_i(opa[0][31:0]), .operand_b_i(opb[0][31:0]), .alu_op_i(opc[0]),
      .rob_id_i(rob_in[0]), .phys_dest_i(dst_in[0]), .valid_o(vo[0]), .ready_i(ready),
      .result_o(res32), .rob_id_o(rob_o[0]), .phys_dest_o(dst_o[0]),
      .exception_o(exc_o[0]), .busy_o(busy[0]));

   pipelined_alu #(.XLEN(64), .STAGES(1)) d1 (
      .clk(clk), .rst(rst), .flush_i(flush), .valid_i(va[1]), .ready_o(rdy[1]),
      .operand_a_i(opa[1]), .operand_b_i(opb[1]), .alu_op_i(opc[1]),
      .rob_id_i(rob_in[1]), .phys_dest_i(dst_in[1]), .valid_o(vo[1]), .ready_i(ready),
      .result_o(res[1]), .rob_id_o(rob_o[1]), .phys_dest_o(dst_o[1]),
      .exception_o(exc_o[1]), .busy_o(busy[1]));

   pipelined_alu #(.XLEN(64), .STAGES(4)) d4 (
      .clk(clk), .rst(rst), .flush_i(flush), .valid_i(va[2]), .ready_o(rdy[2]),
      .operand_a_i(opa[2]), .operand_b_i(opb[2]), .alu_op_i(opc[2]),
      .rob_id_i(rob_in[2]), .phys_dest_i(dst_in[2]), .valid_o(vo[2]), .ready_i(ready),
      .result_o(res[2]), .rob_id_o(rob_o[2]), .phys_dest_o(dst_o[2]),
      .exception_o(exc_o[2]), .busy_o(busy[2]));

   vec_t        tbl [$];
   vec_t        stim [$];
   exp_t        sb [N][$];
   int          ptr [N];
   int          total = 0;
   int          bad = 0;
   int          cyc;
   bit          held [N];
   logic [63:0] h_res [N];
   logic [5:0]  h_rob [N];
   logic [6:0]  h_dst [N];
   logic        h_exc [N];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   // Reference model: bit 64 is the exception flag, result zero-extended for 32-bit.
   function automatic logic [64:0] model(input logic [3:0] op, input logic [63:0] a,
                                         input logic [63:0] b, input bit wide);
      logic [63:0] x, y, r;
      logic signed [63:0] sx, sy;
      int sh;
      logic e;
      if (wide) begin
         x = a; y = b; sh = int'(b[5:0]);
         sx = $signed(a); sy = $signed(b);
      end else begin
         x = {32'h0, a[31:0]}; y = {32'h0, b[31:0]}; sh = int'(b[4:0]);
         sx = $signed({{32{a[31]}}, a[31:0]}); sy = $signed({{32{b[31]}}, b[31:0]});
      end
      e = 1'b0;
      case (op)
         4'h0: r = x + y;
         4'h1: r = x - y;
         4'h2: r = x & y;
         4'h3: r = x | y;
         4'h4: r = x ^ y;
         4'h5: r = x << sh;
         4'h6: r = x >> sh;
         4'h7: r = sx >>> sh;
         4'h8: r = (sx < sy) ? 64'd1 : 64'd0;
         4'h9: r = (x < y) ? 64'd1 : 64'd0;
         4'hA: r = (sx < sy) ? x : y;
         4'hB: r = (sx < sy) ? y : x;
         4'hC: r = (x < y) ? x : y;
         4'hD: r = (x < y) ? y : x;
         default: begin r = 64'h0; e = 1'b1; end
      endcase
      if (!wide) r[63:32] = 32'h0;
      return {e, r};
   endfunction

   function automatic vec_t mk(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                               input logic [5:0] rob, input logic [6:0] dst);
      vec_t v;
      logic [64:0] r32, r64;
      r32 = model(op, a, b, 1'b0);
      r64 = model(op, a, b, 1'b1);
      v.op = op; v.a = a; v.b = b; v.rob = rob; v.dst = dst;
      v.e32 = r32[63:0]; v.e64 = r64[63:0]; v.exc = r64[64];
      return v;
   endfunction

   // mode: 0 clean, 1 random stall/flush, 2 stall on first beat, 3 flush at evt, 4 reset at evt
   task automatic run(input int mode, input int evt, input int maxc);
      int   stall_left;
      bit   stall_armed, saw_full, flush_prev, rst_prev, done;
      exp_t e;
      stall_left = 0; stall_armed = (mode == 2); saw_full = 1'b0;
      flush_prev = 1'b0; rst_prev = 1'b0; cyc = 0;
      for (int i = 0; i < N; i++) begin ptr[i] = 0; held[i] = 1'b0; end
      forever begin
         done = 1'b1;
         for (int i = 0; i < N; i++)
            if (ptr[i] < stim.size() || sb[i].size() != 0) done = 1'b0;
         if (done) break;
         if (cyc >= maxc) begin
            total++; bad++;
            $display("FAIL timeout mode %0d: got %0d cycles want < %0d", mode, cyc, maxc);
            break;
         end
         flush = (mode == 1 && $urandom_range(0, 19) == 0) || (mode == 3 && cyc == evt);
         rst   = (mode == 4 && cyc == evt);
         if (stall_armed && vo[0]) begin stall_left = 3; stall_armed = 1'b0; end
         case (mode)
            1:       ready = ($urandom_range(0, 3) != 0);
            2:       ready = (stall_left == 0);
            4:       ready = (cyc > evt);
            default: ready = 1'b1;
         endcase
         for (int i = 0; i < N; i++) begin
            if (ptr[i] < stim.size()) begin
               va[i] = (mode != 1) || ($urandom_range(0, 3) != 0);
               opc[i] = stim[ptr[i]].op; opa[i] = stim[ptr[i]].a; opb[i] = stim[ptr[i]].b;
               rob_in[i] = stim[ptr[i]].rob; dst_in[i] = stim[ptr[i]].dst;
            end else begin
               va[i] = 1'b0; opc[i] = 4'h0; opa[i] = '0; opb[i] = '0; rob_in[i] = '0; dst_in[i] = '0;
            end
         end
         #1;
         for (int i = 0; i < N; i++) begin
            if (rst_prev) begin
               chk($sformatf("d%0d rst valid", i), 64'(vo[i]), 64'd0);
               chk($sformatf("d%0d rst result", i), res[i], 64'd0);
               chk($sformatf("d%0d rst rob", i), 64'(rob_o[i]), 64'd0);
               chk($sformatf("d%0d rst dest", i), 64'(dst_o[i]), 64'd0);
               chk($sformatf("d%0d rst exc", i), 64'(exc_o[i]), 64'd0);
               chk($sformatf("d%0d rst ready", i), 64'(rdy[i]), 64'd1);
            end
            if (flush_prev) chk($sformatf("d%0d flush valid", i), 64'(vo[i]), 64'd0);
            chk($sformatf("d%0d busy", i), 64'(busy[i]), 64'(sb[i].size() != 0));
            if (held[i]) begin
               chk($sformatf("d%0d hold valid", i), 64'(vo[i]), 64'd1);
               chk($sformatf("d%0d hold result", i), res[i], h_res[i]);
               chk($sformatf("d%0d hold tags", i), {rob_o[i], dst_o[i], exc_o[i]},
                   {h_rob[i], h_dst[i], h_exc[i]});
            end
            if (mode == 0) chk($sformatf("d%0d ready stream", i), 64'(rdy[i]), 64'd1);
            if (mode == 2 && i == 0 && !rdy[i]) saw_full = 1'b1;
            if (rst) begin
               sb[i].delete();
               held[i] = 1'b0;
               continue;
            end
            if (vo[i] && ready && !flush) begin
               if (sb[i].size() == 0) begin
                  total++; bad++;
                  $display("FAIL d%0d spurious beat: got rob %h want none", i, rob_o[i]);
               end else begin
                  e = sb[i].pop_front();
                  chk($sformatf("d%0d result", i), res[i], e.res);
                  chk($sformatf("d%0d rob", i), 64'(rob_o[i]), 64'(e.rob));
                  chk($sformatf("d%0d dest", i), 64'(dst_o[i]), 64'(e.dst));
                  chk($sformatf("d%0d exc", i), 64'(exc_o[i]), 64'(e.exc));
                  if (mode == 0) chk($sformatf("d%0d latency", i), 64'(cyc - e.t), 64'(st[i]));
               end
            end
            held[i] = vo[i] && !ready && !flush;
            h_res[i] = res[i]; h_rob[i] = rob_o[i]; h_dst[i] = dst_o[i]; h_exc[i] = exc_o[i];
            if (flush) sb[i].delete();
            else if (va[i] && rdy[i]) begin
               e.res = w64[i] ? stim[ptr[i]].e64 : stim[ptr[i]].e32;
               e.rob = stim[ptr[i]].rob; e.dst = stim[ptr[i]].dst;
               e.exc = stim[ptr[i]].exc; e.t = cyc;
               sb[i].push_back(e);
               ptr[i]++;
            end
         end
         flush_prev = flush; rst_prev = rst;
         if (stall_left > 0) stall_left--;
         @(posedge clk);
         @(negedge clk);
         cyc++;
      end
      flush = 1'b0; rst = 1'b0; ready = 1'b1;
      for (int i = 0; i < N; i++) va[i] = 1'b0;
      if (mode == 2) chk("d0 ready drop when full", 64'(saw_full), 64'd1);
   endtask

   initial begin
      // {op, a, b, rob, dest, expected 32-bit, expected 64-bit, exception}
      tbl.push_back('{4'h0, 64'hFFFF_FFFF, 64'h1, 6'd5, 7'd9, 64'h0, 64'h1_0000_0000, 1'b0});
      tbl.push_back('{4'h1, 64'h0, 64'h1, 6'd1, 7'd10, 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0});
      tbl.push_back('{4'h2, 64'hF0F0, 64'hFF00, 6'd2, 7'd11, 64'hF000, 64'hF000, 1'b0});
      tbl.push_back('{4'h3, 64'hF0F0, 64'h0F00, 6'd3, 7'd12, 64'hFFF0, 64'hFFF0, 1'b0});
      tbl.push_back('{4'h4, 64'hFF00, 64'h0FF0, 6'd4, 7'd13, 64'hF0F0, 64'hF0F0, 1'b0});
      tbl.push_back('{4'h5, 64'h1, 64'd36, 6'd6, 7'd14, 64'h10, 64'h10_0000_0000, 1'b0});
      tbl.push_back('{4'h6, 64'h8000_0000_0000_0000, 64'd63, 6'd7, 7'd15, 64'h0, 64'h1, 1'b0});
      tbl.push_back('{4'h7, 64'h8000_0000_0000_0000, 64'd63, 6'd8, 7'd16, 64'h0,
                      64'hFFFF_FFFF_FFFF_FFFF, 1'b0});
      tbl.push_back('{4'h7, 64'h8000_0000, 64'd4, 6'd9, 7'd17, 64'hF800_0000, 64'h0800_0000, 1'b0});
      tbl.push_back('{4'h8, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 6'd10, 7'd18, 64'h1, 64'h1, 1'b0});
      tbl.push_back('{4'h8, 64'h8000_0000, 64'h1, 6'd11, 7'd19, 64'h1, 64'h0, 1'b0});
      tbl.push_back('{4'h9, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 6'd12, 7'd20, 64'h0, 64'h0, 1'b0});
      tbl.push_back('{4'hA, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 6'd13, 7'd21, 64'hFFFF_FFFF,
                      64'hFFFF_FFFF_FFFF_FFFF, 1'b0});
      tbl.push_back('{4'hB, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 6'd14, 7'd22, 64'd5, 64'd5, 1'b0});
      tbl.push_back('{4'hC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 6'd15, 7'd23, 64'd3, 64'd3, 1'b0});
      tbl.push_back('{4'hD, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 6'd16, 7'd24, 64'hFFFF_FFFF,
                      64'hFFFF_FFFF_FFFF_FFFF, 1'b0});
      tbl.push_back('{4'hE, 64'd7, 64'd7, 6'd17, 7'd25, 64'h0, 64'h0, 1'b1});
      tbl.push_back('{4'hF, 64'd7, 64'd7, 6'd18, 7'd26, 64'h0, 64'h0, 1'b1});

      rst = 1'b1; flush = 1'b0; ready = 1'b1;
      for (int i = 0; i < N; i++) begin
         va[i] = 1'b0; opc[i] = 4'h0; opa[i] = '0; opb[i] = '0; rob_in[i] = '0; dst_in[i] = '0;
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      for (int i = 0; i < N; i++) begin
         chk($sformatf("d%0d reset valid", i), 64'(vo[i]), 64'd0);
         chk($sformatf("d%0d reset result", i), res[i], 64'd0);
         chk($sformatf("d%0d reset tags", i), {rob_o[i], dst_o[i], exc_o[i]}, 64'd0);
         chk($sformatf("d%0d reset busy", i), 64'(busy[i]), 64'd0);
         chk($sformatf("d%0d reset ready", i), 64'(rdy[i]), 64'd1);
      end

      stim = tbl;
      run(0, 0, 200);

      stim.delete();
      for (int k = 0; k < 4; k++) stim.push_back(mk(4'(k), 64'd100 + 64'(k), 64'd3, 6'(20 + k), 7'(40 + k)));
      run(2, 0, 200);

      stim.delete();
      for (int k = 0; k < 3; k++) stim.push_back(mk(4'h0, 64'(k), 64'd1000, 6'(30 + k), 7'(50 + k)));
      run(3, 2, 200);

      stim.delete();
      for (int k = 0; k < 3; k++) stim.push_back(mk(4'h4, 64'(k), 64'hAA, 6'(40 + k), 7'(60 + k)));
      run(4, 4, 200);

      stim.delete();
      for (int k = 0; k < 150; k++) begin
         logic [63:0] a, b;
         a = {$urandom, $urandom};
         b = {$urandom, $urandom};
         if (k % 7 == 0) a = 64'hFFFF_FFFF_FFFF_FFFF;
         if (k % 5 == 0) b = 64'(k);
         stim.push_back(mk(4'($urandom_range(0, 15)), a, b, 6'(k), 7'(k + 3)));
      end
      run(1, 0, 3000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
